// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR tap engine: default tap table, LFSR step
// function and the tap-search FSM state encoding.
package lfsr_pkg;

  localparam int LFSR_W    = 7;
  localparam int TAP_DEPTH = 9;
  localparam logic [LFSR_W-1:0] TAP_OOR = 7'h48;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CMP,
    FOUND,
    FAIL
  } search_state_t;

  // Entries beyond the shipped table fall back to the out-of-range pattern.
  function automatic logic [LFSR_W-1:0] tap_default(input int idx);
    case (idx)
      0:       return 7'h60;
      1:       return 7'h48;
      2:       return 7'h78;
      3:       return 7'h72;
      4:       return 7'h6A;
      5:       return 7'h69;
      6:       return 7'h5C;
      7:       return 7'h7E;
      8:       return 7'h7B;
      default: return TAP_OOR;
    endcase
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] t);
    return {s[LFSR_W-2:0], ^(s & t)};
  endfunction

endpackage

// File: rtl/lfsr_obs_buf.sv
// Observation buffer for the tap search: fills in order, drops pushes once
// full, read back by compare index.
module lfsr_obs_buf #(
  parameter int WIDTH      = 7,
  parameter int SEARCH_LEN = 4,
  parameter int KW         = 2,
  parameter int CW         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    rd_idx,
  output logic             full,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [CW-1:0] CNT_FULL = CW'(SEARCH_LEN);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mem [SEARCH_LEN];
  logic             wr;

  assign full    = (cnt == CNT_FULL);
  assign wr      = push && !clr && !full;
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (wr) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[cnt[KW-1:0]] <= data;
    end
  end

endmodule

// File: rtl/lfsr_tap_engine.sv
// LFSR tap table, state register and tap-search FSM.
// Define LFSR_TAP_TABLE_WR_EN to make the tap table writable through tbl_*.
module lfsr_tap_engine
  import lfsr_pkg::*;
#(
  parameter int WIDTH      = LFSR_W,
  parameter int DEPTH      = TAP_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int SEARCH_LEN = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [IDX_W-1:0] sel_idx,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] tap_out,
  output logic [WIDTH-1:0] state_out,
  input  logic             obs_valid,
  input  logic [WIDTH-1:0] obs_data,
  input  logic             obs_clr,
  input  logic             search_start,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] found_idx,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_waddr,
  input  logic [WIDTH-1:0] tbl_wdata
);

  localparam int KW = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN) : 1;
  localparam int CW = $clog2(SEARCH_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [KW-1:0]    K_LAST   = KW'(SEARCH_LEN - 1);

  logic [WIDTH-1:0] tbl [DEPTH];
  search_state_t    fsm;
  logic [IDX_W-1:0] cand;
  logic [KW-1:0]    k;
  logic             obs_full;
  logic [WIDTH-1:0] obs_rd;
  logic [WIDTH-1:0] nxt;

`ifdef LFSR_TAP_TABLE_WR_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= tap_default(i);
      end
    end else if (tbl_we && !busy && (tbl_waddr <= LAST_IDX)) begin
      tbl[tbl_waddr] <= tbl_wdata;
    end
  end
`else
  for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
    assign tbl[g] = tap_default(g);
  end

  logic tbl_unused;
  assign tbl_unused = ^{tbl_we, tbl_waddr, tbl_wdata};
`endif

  assign tap_out = (sel_idx <= LAST_IDX) ? tbl[sel_idx] : TAP_OOR;
  assign nxt     = lfsr_next(state_out, tbl[cand]);

  lfsr_obs_buf #(
    .WIDTH      (WIDTH),
    .SEARCH_LEN (SEARCH_LEN),
    .KW         (KW),
    .CW         (CW)
  ) u_obs_buf (
    .clk     (Clk),
    .rst     (Reset),
    .clr     (obs_clr && !busy),
    .push    (obs_valid && !busy),
    .data    (obs_data),
    .rd_idx  (k),
    .full    (obs_full),
    .rd_data (obs_rd)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm       <= IDLE;
      state_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      found_idx <= '0;
      cand      <= '0;
      k         <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        INIT: begin
          state_out <= seed;
          k         <= '0;
          fsm       <= CMP;
        end
        CMP: begin
          if (nxt == obs_rd) begin
            state_out <= nxt;
            if (k == K_LAST) begin
              fsm       <= FOUND;
              done      <= 1'b1;
              found     <= 1'b1;
              found_idx <= cand;
              busy      <= 1'b0;
            end else begin
              k <= k + 1'b1;
            end
          end else if (cand == LAST_IDX) begin
            fsm       <= FAIL;
            done      <= 1'b1;
            state_out <= seed;
            busy      <= 1'b0;
          end else begin
            cand <= cand + 1'b1;
            fsm  <= INIT;
          end
        end
        // IDLE, FOUND and FAIL all have busy low: the datapath is free.
        default: begin
          fsm <= IDLE;
          if (load) begin
            state_out <= seed;
          end else if (step) begin
            state_out <= lfsr_next(state_out, tap_out);
          end
          if (search_start) begin
            found <= 1'b0;
            if (obs_full) begin
              cand <= '0;
              busy <= 1'b1;
              fsm  <= INIT;
            end else begin
              done      <= 1'b1;
              found_idx <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_tap_engine.sv
// Directed bench for lfsr_tap_engine with a queue-based scoreboard.
module tb_lfsr_tap_engine;

  localparam int WIDTH      = 7;
  localparam int DEPTH      = 9;
  localparam int IDX_W      = 4;
  localparam int SEARCH_LEN = 4;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] seed;
  logic             load, step;
  logic [WIDTH-1:0] tap_out, state_out;
  logic             obs_valid;
  logic [WIDTH-1:0] obs_data;
  logic             obs_clr, search_start;
  logic             busy, done, found;
  logic [IDX_W-1:0] found_idx;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [WIDTH-1:0] tbl_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic             fnd;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] st;
    logic [7:0]       lat;
  } srch_t;

  srch_t            sq[$];
  logic [WIDTH-1:0] stq[$];

  logic [WIDTH-1:0] ref_tap [DEPTH] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                        7'h69, 7'h5C, 7'h7E, 7'h7B};
  logic [WIDTH-1:0] walk [6] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};

  lfsr_tap_engine #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .SEARCH_LEN(SEARCH_LEN)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .sel_idx      (sel_idx),
    .seed         (seed),
    .load         (load),
    .step         (step),
    .tap_out      (tap_out),
    .state_out    (state_out),
    .obs_valid    (obs_valid),
    .obs_data     (obs_data),
    .obs_clr      (obs_clr),
    .search_start (search_start),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .found_idx    (found_idx),
    .tbl_we       (tbl_we),
    .tbl_waddr    (tbl_waddr),
    .tbl_wdata    (tbl_wdata)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_obs(input logic [WIDTH-1:0] d);
    obs_valid = 1'b1;
    obs_data  = d;
    tick();
    obs_valid = 1'b0;
  endtask

  task automatic clr_obs();
    obs_clr = 1'b1;
    tick();
    obs_clr = 1'b0;
  endtask

  task automatic run_search(input string tag, input logic fnd, input logic [IDX_W-1:0] idx,
                            input logic [WIDTH-1:0] st, input int lat, input bit poke);
    int    lat_n;
    srch_t e;
    sq.push_back(srch_t'{fnd, idx, st, 8'(lat)});
    search_start = 1'b1;
    tick();
    search_start = 1'b0;
    lat_n = 1;
    e = sq.pop_front();
    chk({tag, ".busy1"}, 32'(busy), 32'(e.lat > 8'd1));
    if (poke) step = 1'b1;
    while (!done && lat_n < 300) begin
      tick();
      lat_n++;
    end
    step = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'(1));
    chk({tag, ".lat"}, 32'(lat_n), 32'(e.lat));
    chk({tag, ".found"}, 32'(found), 32'(e.fnd));
    chk({tag, ".idx"}, 32'(found_idx), 32'(e.idx));
    chk({tag, ".state"}, 32'(state_out), 32'(e.st));
    chk({tag, ".busy_done"}, 32'(busy), 32'(0));
    tick();
    chk({tag, ".pulse"}, 32'(done), 32'(0));
  endtask

  initial begin
    int pulses;
    Reset = 1'b1; sel_idx = '0; seed = '0; load = 1'b0; step = 1'b0;
    obs_valid = 1'b0; obs_data = '0; obs_clr = 1'b0; search_start = 1'b0;
    tbl_we = 1'b0; tbl_waddr = '0; tbl_wdata = '0;
    tick();
    tick();
    chk("rst.state", 32'(state_out), 32'(0));
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    chk("rst.found", 32'(found), 32'(0));
    chk("rst.idx", 32'(found_idx), 32'(0));
    Reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      sel_idx = IDX_W'(i);
      #1;
      chk($sformatf("tap[%0d]", i), 32'(tap_out), 32'(ref_tap[i]));
    end

    // Load 0x01 and walk six steps under tap 0x60.
    sel_idx = '0; seed = 7'h01; load = 1'b1;
    tick();
    load = 1'b0;
    chk("load01", 32'(state_out), 32'(7'h01));
    chk("tap0", 32'(tap_out), 32'(7'h60));
    step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      stq.push_back(walk[i]);
      tick();
      chk($sformatf("walk%0d", i), 32'(state_out), 32'(stq.pop_front()));
    end
    step = 1'b0;

    // Load beats step.
    seed = 7'h7F; load = 1'b1;
    tick();
    chk("load7f", 32'(state_out), 32'(7'h7F));
    step = 1'b1;
    tick();
    load = 1'b0; step = 1'b0;
    chk("load_prio", 32'(state_out), 32'(7'h7F));
    sel_idx = 4'd9;
    #1;
    chk("tap_oor", 32'(tap_out), 32'(7'h48));
    sel_idx = '0;

    seed = 7'h01;
    clr_obs();
    push_obs(7'h02); push_obs(7'h04); push_obs(7'h08); push_obs(7'h10);
    run_search("s_idx0", 1'b1, 4'd0, 7'h10, 6, 1'b1);

    clr_obs();
    push_obs(7'h02); push_obs(7'h04); push_obs(7'h08); push_obs(7'h11);
    run_search("s_idx1", 1'b1, 4'd1, 7'h11, 11, 1'b0);

    clr_obs();
    push_obs(7'h02); push_obs(7'h04);
    run_search("s_short", 1'b0, 4'd0, 7'h11, 1, 1'b0);

    clr_obs();
    push_obs(7'h02); push_obs(7'h04); push_obs(7'h08); push_obs(7'h13);
    run_search("s_none", 1'b0, 4'd0, 7'h01, 33, 1'b0);

    // Reset while the FSM is comparing.
    search_start = 1'b1;
    tick();
    search_start = 1'b0;
    tick();
    tick();
    chk("mid.busy", 32'(busy), 32'(1));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_rst.busy", 32'(busy), 32'(0));
    chk("mid_rst.state", 32'(state_out), 32'(0));
    chk("mid_rst.done", 32'(done), 32'(0));
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("mid_rst.no_done", 32'(pulses), 32'(0));
    run_search("s_post_rst", 1'b0, 4'd0, 7'h00, 1, 1'b0);

    // Table write strobe.
    seed = 7'h01;
    push_obs(7'h02); push_obs(7'h04); push_obs(7'h08); push_obs(7'h11);
    tbl_we = 1'b1; tbl_waddr = 4'd0; tbl_wdata = 7'h48;
    tick();
    tbl_we = 1'b0;
    sel_idx = '0;
    #1;
`ifdef LFSR_TAP_TABLE_WR_EN
    chk("wr.tap0", 32'(tap_out), 32'(7'h48));
    run_search("s_wr", 1'b1, 4'd0, 7'h11, 6, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("wr.rst_tap0", 32'(tap_out), 32'(7'h60));
`else
    chk("nowr.tap0", 32'(tap_out), 32'(7'h60));
    run_search("s_nowr", 1'b1, 4'd1, 7'h11, 11, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
